dsp_mac_sequencer: RTL

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

---
 rtl/dsp_mac_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer that streams operand pairs into a MAC-mode dsp_slice and captures the sum.
// Optional stall counter enabled by defining SEQ_STALL_CNT_EN.
module dsp_mac_sequencer #(
  parameter int DWIDTH = 16,
  parameter int LEN_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [LEN_W-1:0]         len_i,
  output logic                     busy_o,
  input  logic                     op_valid_i,
  output logic                     op_ready_o,
  input  logic signed [DWIDTH-1:0] op_a_i,
  input  logic signed [DWIDTH-1:0] op_b_i,
  output logic signed [DWIDTH-1:0] dsp_a_o,
  output logic signed [DWIDTH-1:0] dsp_b_o,
  output logic [2:0]               dsp_mode_o,
  output logic                     dsp_clr_o,
  output logic                     dsp_cin_o,
  input  logic [DWIDTH-1:0]        dsp_c_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [DWIDTH-1:0]        res_data_o,
  output logic [15:0]              stall_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [1:0]         drain_q, drain_d;
  logic [DWIDTH-1:0]  res_q, res_d;
  logic               xfer;
  logic               start_ok;

  assign xfer     = (state_q == S_FEED) && op_valid_i;
  assign start_ok = (state_q == S_IDLE) && start_i;

  // Three drain cycles cover the slice's multiply and accumulate registers.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    drain_d = drain_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d = S_CLEAR;
            rem_d   = len_i;
          end else begin
            state_d = S_HOLD;
            res_d   = '0;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        drain_d = '0;
      end
      S_FEED: begin
        if (xfer) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          res_d   = dsp_c_i;
          drain_d = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      drain_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      drain_q <= drain_d;
      res_q   <= res_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign op_ready_o  = (state_q == S_FEED);
  assign dsp_a_o     = xfer ? op_a_i : '0;
  assign dsp_b_o     = xfer ? op_b_i : '0;
  assign dsp_mode_o  = 3'b100;
  assign dsp_cin_o   = 1'b0;
  // Held high through reset so the slice accumulator is flushed along with the sequencer.
  assign dsp_clr_o   = !rst_ni || (state_q == S_CLEAR);
  assign res_valid_o = (state_q == S_HOLD);
  assign res_data_o  = res_q;

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall_d = stall_q;
    if (start_ok && (len_i != '0)) begin
      stall_d = '0;
    end else if ((state_q == S_FEED) && !op_valid_i) begin
      stall_d = sat_inc16(stall_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
